// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC register and IF/ID pipeline register
module fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        exc_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8,
    output logic        d_bd,
    output logic        d_exc,
    output logic [4:0]  d_exccode
);

    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc;
    logic        fe;
    logic [31:0] cap_instr;
    logic        cap_exc;
    logic [4:0]  cap_exccode;

    assign im_addr = pc;

    // Fetch address error on the current PC and what IF/ID would capture from it
    always_comb begin
        fe          = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
        cap_instr   = im_instr;
        cap_exc     = 1'b0;
        cap_exccode = 5'd0;
        if (fe) begin
            cap_instr   = 32'd0;
            cap_exc     = 1'b1;
            cap_exccode = EXC_ADEL;
        end
    end

    // PC and IF/ID update: exception entry beats stall, stall beats redirects
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= PC_RESET;
            d_instr   <= 32'd0;
            d_pc      <= PC_RESET;
            d_pc8     <= PC_RESET + 32'd8;
            d_bd      <= 1'b0;
            d_exc     <= 1'b0;
            d_exccode <= 5'd0;
        end else if (exc_req) begin
            pc        <= EXC_VECTOR;
            d_instr   <= 32'd0;
            d_pc      <= pc;
            d_pc8     <= pc + 32'd8;
            d_bd      <= 1'b0;
            d_exc     <= 1'b0;
            d_exccode <= 5'd0;
        end else if (!stall) begin
            d_pc  <= pc;
            d_pc8 <= pc + 32'd8;
            if (eret) begin
                // eret has no delay slot: squash the sequential fetch
                pc        <= epc;
                d_instr   <= 32'd0;
                d_bd      <= 1'b0;
                d_exc     <= 1'b0;
                d_exccode <= 5'd0;
            end else begin
                pc        <= branch_taken ? branch_target : pc + 32'd4;
                d_instr   <= cap_instr;
                d_bd      <= branch & ~eret;
                d_exc     <= cap_exc;
                d_exccode <= cap_exccode;
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register.
- Feeds the decode stage, where the control decoder consumes `d_instr`.
- Takes redirects resolved in decode (branch/jump target, eret→EPC) and exception entry from CP0.
- Handles stall and flush, tags branch-delay-slot instructions, and detects fetch address errors (AdEL).

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset
EXC_VECTOR, 32'h0000_4180, exception/interrupt handler entry
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
stall  in  1  hazard unit: hold PC and IF/ID
branch  in  1  decode holds a branch/jump/eret (decoder `branch` output)
branch_taken  in  1  decode resolved redirect to branch_target
branch_target  in  32  redirect address from decode
eret  in  1  decode holds eret
epc  in  32  CP0 EPC
exc_req  in  1  CP0 taking exception/interrupt this cycle
im_addr  out  32  instruction memory address (= PC)
im_instr  in  32  instruction memory read data (combinational, same cycle)
d_instr  out  32  IF/ID instruction
d_pc  out  32  IF/ID PC
d_pc8  out  32  IF/ID PC+8 (link value)
d_bd  out  1  IF/ID instruction is in a branch delay slot
d_exc  out  1  IF/ID instruction carries a fetch exception
d_exccode  out  5  exception code (4 = AdEL, else 0)

Behaviour:
- Reset (reset=0, async):
  - PC <= PC_RESET.
  - d_instr, d_bd, d_exc, d_exccode <= 0.
  - d_pc <= PC_RESET; d_pc8 <= PC_RESET+8.
- im_addr = PC, always combinational from the PC register.
- Fetch error (combinational on PC): fe = (PC[1:0]!=0) | (PC<IM_BASE) | (PC>IM_LIMIT).
- Per rising edge, first matching row wins:
  1. exc_req=1:
     - PC <= EXC_VECTOR.
     - IF/ID <= bubble: instr=0, bd=0, exc=0, exccode=0, pc=PC, pc8=PC+8.
     - Overrides stall.
  2. stall=1: PC and all IF/ID fields hold. branch_taken and eret are ignored; decode re-presents them next cycle.
  3. eret=1:
     - PC <= epc.
     - IF/ID <= bubble (eret has no delay slot; the sequentially fetched instruction is squashed).
  4. branch_taken=1:
     - PC <= branch_target.
     - IF/ID captures the current fetch; this is the delay slot.
  5. Otherwise: PC <= PC+4 and IF/ID captures the current fetch.
- Capture of the current fetch (rows 4/5):
  - d_pc=PC, d_pc8=PC+8.
  - d_bd = branch & ~eret (taken or not).
  - If fe: d_instr=0, d_exc=1, d_exccode=4.
  - Else: d_instr=im_instr, d_exc=0, d_exccode=0.
- An AdEL does not redirect PC; fetch continues at PC+4 until CP0 asserts exc_req. The misaligned address travels as d_pc for BadVAddr/EPC.
- PC arithmetic is 32-bit modulo; wrap past 0xFFFFFFFC gives 0 (flagged fe).
- branch_target and epc are not aligned by this block; misalignment surfaces as AdEL on the next fetch.
- exc_req asserted during reset has no effect; reset dominates.

Test Plan:
- Reset then 3 free-running cycles, im_instr=32'h3401_0005 → im_addr 0x3000, 0x3004, 0x3008, 0x300C; d_pc=0x3004 and d_pc8=0x300C after the 2nd edge; d_bd=0.
- Branch at d_pc=0x3008 with branch=1, branch_taken=1, target=0x3020 → d_pc=0x300C with d_bd=1, next im_addr=0x3020. Same with branch_taken=0 → d_bd=1, PC=0x3010.
- stall=1 for 2 cycles with branch_taken=1 → PC and d_* unchanged both cycles. Release stall → redirect taken on the first unstalled edge.
- eret=1, epc=0x3040 → PC=0x3040, d_instr=0, d_bd=0.
- exc_req=1 together with stall=1 → PC=0x4180 and IF/ID bubble on the same edge.
- branch_target=0x3002 → next fetch gives d_exc=1, d_exccode=4, d_instr=0, d_pc=0x3002. Also PC=0x7000 via target → AdEL. Assert reset=0 mid-cycle → PC=0x3000 immediately, before any clock edge.
